arbitro_sumador_rr: RTL and testbench
=====================================

Name: arbitro_sumador_rr

Overview:
- Round-robin arbiter and sequencer that shares one external 8-bit ripple-carry adder (SUM_RIZADO) between two requesters.
- Captures the winning requester's operands and drives them onto the adder.
- Waits a programmable number of cycles for the carry chain to settle, then registers the sum and carry.
- Presents the result with a valid/ack handshake tagged with the requester id.
- Sits between the power-analysis datapath and the requesting logic.

Parameters:
- SETTLE_CYCLES, 2, cycles the adder inputs are held before sampling add_s/add_co; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 wants an addition; held until gnt0.
- a0  in  8  requester 0 operand A.
- b0  in  8  requester 0 operand B.
- ci0  in  1  requester 0 carry-in.
- gnt0  out  1  one-cycle grant; operands of requester 0 captured at this edge.
- req1  in  1  requester 1 request.
- a1  in  8  requester 1 operand A.
- b1  in  8  requester 1 operand B.
- ci1  in  1  requester 1 carry-in.
- gnt1  out  1  one-cycle grant to requester 1.
- add_a  out  8  to adder a.
- add_b  out  8  to adder b.
- add_ci  out  1  to adder ci.
- add_s  in  8  from adder s.
- add_co  in  1  from adder co.
- res_s  out  8  registered sum.
- res_co  out  1  registered carry-out.
- res_id  out  1  requester owning the result.
- res_valid  out  1  result available.
- res_ack  in  1  consumer accepts result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE; all outputs 0; operand registers 0; settle counter 0; last_id=1, so requester 0 wins the first tie.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - gnt0/gnt1 are combinational from the req inputs and last_id.
  - At most one grant is high.
  - Only req0: gnt0. Only req1: gnt1. Both: grant the requester != last_id.
  - On a grant edge: capture {a,b,ci} of the winner and the winner id, set last_id=winner, load counter=SETTLE_CYCLES-1, go to SETTLE.
  - No request: stay in IDLE.
- SETTLE:
  - add_a/add_b/add_ci driven from the operand registers.
  - counter decrements each cycle.
  - On the cycle counter==0: register res_s=add_s, res_co=add_co, res_id=captured id; set res_valid=1; go to DONE.
- DONE:
  - res_valid=1; res_s/res_co/res_id held stable.
  - res_ack=1: clear res_valid at that edge and return to IDLE.
  - No new grant in the ack cycle; earliest next grant is the following cycle.
- Latency: grant in cycle T; res_valid first high in cycle T+1+SETTLE_CYCLES (T+3 at default).
- Throughput: with res_ack tied high, one result per SETTLE_CYCLES+2 cycles.
- Arithmetic: {res_co,res_s} = a+b+ci, 9-bit; 255+255+1 gives co=1, s=0xFF.
- Input isolation: req/operand changes during SETTLE/DONE have no effect. Requests are not queued; a request still high on return to IDLE is arbitrated then.
- Deassertion before grant: a requester dropping req before its grant is simply not served.
- res_ack outside DONE: ignored.
- Reset mid-operation: abort immediately; the pending result is discarded and no res_valid is produced.
- SETTLE_CYCLES outside 1..15: elaboration error via generate-time check.

Optional Feature:
- Macro: OPERAND_ISOLATION_EN (power feature).
- Defined: add_a, add_b, add_ci forced to 0 whenever state != SETTLE, removing adder toggling during idle/result-hold for power measurement.
- Undefined: add_* follow the operand registers continuously and hold the last operands in IDLE/DONE.
- res_* timing is identical in both builds.

Test Plan:
- Single request: reset, req0 with a0=0x0F, b0=0x01, ci0=0 → gnt0 pulse at T; res_valid at T+3; res_s=0x10, res_co=0, res_id=0; ack → IDLE.
- Full carry ripple: req1 with a1=0xFF, b1=0xFF, ci1=1 → res_s=0xFF, res_co=1, res_id=1.
- Fairness: req0 and req1 held high continuously, ack tied 1 → grant order 0,1,0,1; each result tagged correctly with its sum.
- Back-pressure: hold res_ack=0 for 10 cycles in DONE → res_valid and res_s stable, no grants while req0 is high; ack → next grant one cycle later.
- Reset mid-SETTLE: assert reset one cycle after gnt0 → next cycle all outputs 0, state IDLE, no res_valid. First tie after release goes to requester 0.
- Isolation, run in both builds with a0=0xAA, b0=0x55:
  - With OPERAND_ISOLATION_EN: add_a=0 in IDLE/DONE and 0xAA only during SETTLE.
  - Without it: add_a stays 0xAA after the operation completes.

Source files
------------

// File: rtl/arbitro_sumador_rr_if.sv
// Bus bundle for arbitro_sumador_rr: two requester ports, the shared
// external adder connection and the result handshake.
// slave  : view of the arbiter itself.
// master : view of the surrounding logic (requesters, adder, consumer).
interface arbitro_sumador_rr_if;
  logic       req0;
  logic [7:0] a0;
  logic [7:0] b0;
  logic       ci0;
  logic       gnt0;
  logic       req1;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       ci1;
  logic       gnt1;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_ci;
  logic [7:0] add_s;
  logic       add_co;
  logic [7:0] res_s;
  logic       res_co;
  logic       res_id;
  logic       res_valid;
  logic       res_ack;
  logic       busy;

  modport slave (
    input  req0, a0, b0, ci0, req1, a1, b1, ci1, add_s, add_co, res_ack,
    output gnt0, gnt1, add_a, add_b, add_ci, res_s, res_co, res_id,
           res_valid, busy
  );

  modport master (
    output req0, a0, b0, ci0, req1, a1, b1, ci1, add_s, add_co, res_ack,
    input  gnt0, gnt1, add_a, add_b, add_ci, res_s, res_co, res_id,
           res_valid, busy
  );
endinterface

// File: rtl/arbitro_sumador_rr.sv
// Round-robin arbiter/sequencer sharing one external 8-bit ripple adder
// between two requesters. The winner's operands are captured, held on the
// adder for SETTLE_CYCLES cycles, then sum/carry are registered and offered
// through a valid/ack handshake tagged with the requester id.
// Optional build macro OPERAND_ISOLATION_EN: adder inputs are forced to zero
// outside the SETTLE state to stop adder toggling while idle/holding.
module arbitro_sumador_rr #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset,
  arbitro_sumador_rr_if.slave  bus
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_settle_range_check
    $error("arbitro_sumador_rr: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [3:0] LP_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  state_t     r_state;
  logic       r_last_id;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  logic       r_op_ci;
  logic       r_op_id;
  logic [3:0] r_cnt;
  logic [7:0] r_res_s;
  logic       r_res_co;
  logic       r_res_id;
  logic       r_res_valid;

  logic       w_idle;
  logic       w_gnt0;
  logic       w_gnt1;

  // Grants are combinational in IDLE; reset masks them so every output is
  // quiet while reset is applied. On a tie the requester that did not win
  // last time is served.
  assign w_idle = (r_state == IDLE) && !reset;
  assign w_gnt0 = w_idle && bus.req0 && (!bus.req1 || r_last_id);
  assign w_gnt1 = w_idle && bus.req1 && (!bus.req0 || !r_last_id);

  // Arbitration, settle countdown and result handshake sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_id   <= 1'b1;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_ci     <= 1'b0;
      r_op_id     <= 1'b0;
      r_cnt       <= '0;
      r_res_s     <= '0;
      r_res_co    <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0) begin
            r_op_a    <= bus.a0;
            r_op_b    <= bus.b0;
            r_op_ci   <= bus.ci0;
            r_op_id   <= 1'b0;
            r_last_id <= 1'b0;
            r_cnt     <= LP_CNT_LOAD;
            r_state   <= SETTLE;
          end else if (w_gnt1) begin
            r_op_a    <= bus.a1;
            r_op_b    <= bus.b1;
            r_op_ci   <= bus.ci1;
            r_op_id   <= 1'b1;
            r_last_id <= 1'b1;
            r_cnt     <= LP_CNT_LOAD;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_res_s     <= bus.add_s;
            r_res_co    <= bus.add_co;
            r_res_id    <= r_op_id;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.res_ack) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.res_s     = r_res_s;
  assign bus.res_co    = r_res_co;
  assign bus.res_id    = r_res_id;
  assign bus.res_valid = r_res_valid;
  assign bus.busy      = (r_state != IDLE);

`ifdef OPERAND_ISOLATION_EN
  logic w_iso_pass;
  assign w_iso_pass = (r_state == SETTLE);
  assign bus.add_a  = w_iso_pass ? r_op_a  : '0;
  assign bus.add_b  = w_iso_pass ? r_op_b  : '0;
  assign bus.add_ci = w_iso_pass ? r_op_ci : 1'b0;
`else
  assign bus.add_a  = r_op_a;
  assign bus.add_b  = r_op_b;
  assign bus.add_ci = r_op_ci;
`endif

endmodule

// File: tb/tb_arbitro_sumador_rr.sv
// Self-checking bench for arbitro_sumador_rr: vector table of single
// operations plus sequences for fairness, back-pressure, reset abort and
// operand isolation. A negedge monitor keeps a scoreboard of expected
// results pushed at each grant and popped when res_valid rises.
module tb_arbitro_sumador_rr;

  localparam int unsigned SC = 2;

`ifdef OPERAND_ISOLATION_EN
  localparam logic [7:0] EXP_IDLE_A = 8'h00;
`else
  localparam logic [7:0] EXP_IDLE_A = 8'hAA;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_sumador_rr_if u_if ();

  arbitro_sumador_rr #(.SETTLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  // External ripple adder model
  always_comb {u_if.add_co, u_if.add_s} = 9'(u_if.add_a) + 9'(u_if.add_b) + 9'(u_if.add_ci);

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned id;
    logic [8:0]  sum;
    int unsigned gcyc;
  } sb_t;

  sb_t         sb[$];
  int unsigned gnt_log[$];
  int unsigned gnt_cyc[$];
  bit          prev_valid = 1'b0;

  // Monitor: push expectation on each grant, compare on each new result
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (u_if.gnt0 || u_if.gnt1)
        check("gnt_onehot", 32'(u_if.gnt0 & u_if.gnt1), 32'd0);
      if (u_if.gnt0) begin
        sb.push_back('{0, 9'(u_if.a0) + 9'(u_if.b0) + 9'(u_if.ci0), cyc});
        gnt_log.push_back(0);
        gnt_cyc.push_back(cyc);
      end else if (u_if.gnt1) begin
        sb.push_back('{1, 9'(u_if.a1) + 9'(u_if.b1) + 9'(u_if.ci1), cyc});
        gnt_log.push_back(1);
        gnt_cyc.push_back(cyc);
      end
      if (u_if.res_valid && !prev_valid) begin
        check("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          check("sb_id", 32'(u_if.res_id), e.id);
          check("sb_sum", 32'({u_if.res_co, u_if.res_s}), 32'(e.sum));
          check("sb_latency", cyc - e.gcyc, SC + 1);
        end
      end
      prev_valid = u_if.res_valid;
    end
  end

  typedef struct {
    logic       req0;
    logic       req1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       ci0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       ci1;
    logic       exp_id;
    logic [7:0] exp_s;
    logic       exp_co;
  } vec_t;

  vec_t vt[7];

  task automatic wait_gnt(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (u_if.gnt0 || u_if.gnt1) got = 1'b1;
    end
    check({tag, "_gnt_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_valid(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (u_if.res_valid) got = 1'b1;
    end
    check({tag, "_valid_seen"}, 32'(got), 32'd1);
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1;
    u_if.res_ack = 1'b1;
    @(posedge clk); #1;
    u_if.res_ack = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit          got;
    int unsigned tg;
    @(posedge clk); #1;
    u_if.req0 = v.req0; u_if.a0 = v.a0; u_if.b0 = v.b0; u_if.ci0 = v.ci0;
    u_if.req1 = v.req1; u_if.a1 = v.a1; u_if.b1 = v.b1; u_if.ci1 = v.ci1;
    u_if.res_ack = 1'b0;
    wait_gnt(tag, got);
    if (got) begin
      tg = cyc;
      check({tag, "_gnt0"}, 32'(u_if.gnt0), 32'(!v.exp_id));
      check({tag, "_gnt1"}, 32'(u_if.gnt1), 32'(v.exp_id));
      @(posedge clk); #1;
      // operand changes after the grant must not reach the result
      u_if.req0 = 1'b0; u_if.req1 = 1'b0;
      u_if.a0 = 8'h5A; u_if.b0 = 8'hC3; u_if.ci0 = 1'b1;
      u_if.a1 = 8'h3C; u_if.b1 = 8'h96; u_if.ci1 = 1'b1;
      wait_valid(tag, got);
      if (got) begin
        check({tag, "_latency"}, cyc - tg, SC + 1);
        check({tag, "_res_s"}, 32'(u_if.res_s), 32'(v.exp_s));
        check({tag, "_res_co"}, 32'(u_if.res_co), 32'(v.exp_co));
        check({tag, "_res_id"}, 32'(u_if.res_id), 32'(v.exp_id));
        ack_pulse();
        @(negedge clk);
        check({tag, "_valid_clr"}, 32'(u_if.res_valid), 32'd0);
        check({tag, "_busy_clr"}, 32'(u_if.busy), 32'd0);
      end
    end
  endtask

  task automatic do_reset(input int unsigned n);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int unsigned base;
    int unsigned bp_bad;

    vt[0] = '{1'b1, 1'b0, 8'h0F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0};
    vt[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1};
    vt[2] = '{1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[3] = '{1'b1, 1'b1, 8'h05, 8'h06, 1'b0, 8'h12, 8'h34, 1'b1, 1'b1, 8'h47, 1'b0};
    vt[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0};
    vt[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0};
    vt[6] = '{1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1};

    u_if.req0 = 1'b0; u_if.a0 = '0; u_if.b0 = '0; u_if.ci0 = 1'b0;
    u_if.req1 = 1'b0; u_if.a1 = '0; u_if.b1 = '0; u_if.ci1 = 1'b0;
    u_if.res_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_gnt0", 32'(u_if.gnt0), 32'd0);
    check("rst_gnt1", 32'(u_if.gnt1), 32'd0);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_valid", 32'(u_if.res_valid), 32'd0);
    check("rst_res", 32'({u_if.res_id, u_if.res_co, u_if.res_s}), 32'd0);
    check("rst_add", 32'({u_if.add_ci, u_if.add_b, u_if.add_a}), 32'd0);

    // Vector table
    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Fairness with both requests held and ack tied high
    do_reset(2);
    base = gnt_log.size();
    @(posedge clk); #1;
    u_if.a0 = 8'h01; u_if.b0 = 8'h02; u_if.ci0 = 1'b0;
    u_if.a1 = 8'h10; u_if.b1 = 8'h20; u_if.ci1 = 1'b1;
    u_if.req0 = 1'b1; u_if.req1 = 1'b1; u_if.res_ack = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      if (gnt_log.size() >= base + 4) got = 1'b1;
    end
    u_if.req0 = 1'b0; u_if.req1 = 1'b0;
    check("fair_4_grants", 32'(got), 32'd1);
    if (got) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("fair_order%0d", k), gnt_log[base + k], k % 2);
        if (k > 0)
          check($sformatf("fair_gap%0d", k), gnt_cyc[base + k] - gnt_cyc[base + k - 1], SC + 2);
      end
    end
    repeat (10) @(posedge clk);
    #1 u_if.res_ack = 1'b0;
    check("fair_drain", sb.size(), 0);

    // Back-pressure: result held while ack low, no grants to a waiting req0
    @(posedge clk); #1;
    u_if.req0 = 1'b1; u_if.a0 = 8'h33; u_if.b0 = 8'h44; u_if.ci0 = 1'b0;
    wait_valid("bp", got);
    if (got) begin
      bp_bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!u_if.res_valid || u_if.res_s != 8'h77 || u_if.gnt0 || u_if.gnt1) bp_bad++;
      end
      check("bp_hold_stable", bp_bad, 0);
      check("bp_res_s", 32'(u_if.res_s), 32'h77);
      @(posedge clk); #1;
      u_if.res_ack = 1'b1;
      @(negedge clk);
      check("bp_ack_cycle_gnt", 32'(u_if.gnt0), 32'd0);
      @(posedge clk); #1;
      u_if.res_ack = 1'b0;
      @(negedge clk);
      check("bp_next_gnt", 32'(u_if.gnt0), 32'd1);
      @(posedge clk); #1;
      u_if.req0 = 1'b0;
      wait_valid("bp2", got);
      ack_pulse();
    end

    // Reset one cycle after a grant aborts the operation
    @(posedge clk); #1;
    u_if.req0 = 1'b1; u_if.a0 = 8'hAA; u_if.b0 = 8'h55; u_if.ci0 = 1'b0;
    wait_gnt("rmid", got);
    @(posedge clk); #1;
    u_if.req0 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rmid_gnt", 32'({u_if.gnt1, u_if.gnt0}), 32'd0);
    check("rmid_busy", 32'(u_if.busy), 32'd0);
    check("rmid_valid", 32'(u_if.res_valid), 32'd0);
    check("rmid_res", 32'({u_if.res_id, u_if.res_co, u_if.res_s}), 32'd0);
    check("rmid_add", 32'({u_if.add_ci, u_if.add_b, u_if.add_a}), 32'd0);
    bp_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (u_if.res_valid) bp_bad++;
    end
    check("rmid_no_valid", bp_bad, 0);
    run_vec('{1'b1, 1'b1, 8'hAA, 8'h55, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b0}, "rmid_tie");

    // Operand isolation behaviour
    @(negedge clk);
    check("iso_idle_before", 32'(u_if.add_a), 32'(EXP_IDLE_A));
    @(posedge clk); #1;
    u_if.req0 = 1'b1; u_if.a0 = 8'hAA; u_if.b0 = 8'h55; u_if.ci0 = 1'b0;
    wait_gnt("iso", got);
    @(posedge clk); #1;
    u_if.req0 = 1'b0;
    for (int i = 0; i < int'(SC); i++) begin
      @(negedge clk);
      check($sformatf("iso_settle_a%0d", i), 32'(u_if.add_a), 32'hAA);
      check($sformatf("iso_settle_b%0d", i), 32'(u_if.add_b), 32'h55);
    end
    @(negedge clk);
    check("iso_done_valid", 32'(u_if.res_valid), 32'd1);
    check("iso_done_a", 32'(u_if.add_a), 32'(EXP_IDLE_A));
    ack_pulse();
    @(negedge clk);
    check("iso_idle_after", 32'(u_if.add_a), 32'(EXP_IDLE_A));

    repeat (5) @(posedge clk);
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
